// File: rtl/calc_seq_if.sv
// Sequencer <-> host/calculator signal bundle: program load, run control,
// calculator drive and completion status.
interface calc_seq_if;
    logic        start;
    logic        clr;
    logic [3:0]  len;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [2:0]  wr_op;
    logic [15:0] wr_data;
    logic [15:0] acc_in;
    logic [2:0]  alu_op;
    logic [15:0] alu_sw;
    logic        alu_upd;
    logic        acc_rst;
    logic        busy;
    logic        done;
    logic [2:0]  pc;
    logic [15:0] result;

    modport master (
        output start, clr, len, wr_en, wr_addr, wr_op, wr_data, acc_in,
        input  alu_op, alu_sw, alu_upd, acc_rst, busy, done, pc, result
    );

    modport slave (
        input  start, clr, len, wr_en, wr_addr, wr_op, wr_data, acc_in,
        output alu_op, alu_sw, alu_upd, acc_rst, busy, done, pc, result
    );
endinterface

// File: rtl/calc_seq.sv
// Replays up to 8 stored (op, operand) instructions into an external calculator,
// 3 cycles per instruction, then captures the accumulator. No backpressure.
module calc_seq (
    input  logic       clk,
    input  logic       btnu,
    calc_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CLR, SETUP, PULSE, WAIT, DONE} state_t;

    state_t      state;
    logic [18:0] mem [8];
    logic [3:0]  len_q;
    logic [3:0]  len_eff;
    logic        wr_fire;
    logic        last;
    logic [2:0]  fetch_idx;
    logic [18:0] fetch_dat;

    assign len_eff = (bus.len > 4'd8) ? 4'd8 : bus.len;
    assign wr_fire = bus.wr_en && !bus.busy;
    assign last    = ({1'b0, bus.pc} == (len_q - 4'd1));

    // Slot 0 may be loaded on the very edge that accepts start, so the first
    // fetch forwards the in-flight write instead of the stale array entry.
    always_comb begin
        fetch_idx = (state == WAIT) ? bus.pc + 3'd1 : bus.pc;
        fetch_dat = mem[fetch_idx];
        if (wr_fire && (bus.wr_addr == fetch_idx)) begin
            fetch_dat = {bus.wr_op, bus.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (btnu) begin
            state       <= IDLE;
            len_q       <= 4'd0;
            bus.pc      <= 3'd0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.alu_upd <= 1'b0;
            bus.acc_rst <= 1'b0;
            bus.alu_op  <= 3'd0;
            bus.alu_sw  <= 16'd0;
            bus.result  <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 19'd0;
            end
        end else begin
            bus.done    <= 1'b0;
            bus.acc_rst <= 1'b0;
            bus.alu_upd <= 1'b0;
            if (wr_fire) begin
                mem[bus.wr_addr] <= {bus.wr_op, bus.wr_data};
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q    <= len_eff;
                        bus.busy <= 1'b1;
                        if (bus.clr) begin
                            state       <= CLR;
                            bus.acc_rst <= 1'b1;
                        end else if (len_eff != 4'd0) begin
                            state                    <= SETUP;
                            {bus.alu_op, bus.alu_sw} <= fetch_dat;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                CLR: begin
                    if (len_q != 4'd0) begin
                        state                    <= SETUP;
                        {bus.alu_op, bus.alu_sw} <= fetch_dat;
                    end else begin
                        state <= DONE;
                    end
                end
                SETUP: begin
                    state       <= PULSE;
                    bus.alu_upd <= 1'b1;
                end
                PULSE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (last) begin
                        state      <= DONE;
                        bus.alu_op <= 3'd0;
                        bus.alu_sw <= 16'd0;
                    end else begin
                        state                    <= SETUP;
                        bus.pc                   <= bus.pc + 3'd1;
                        {bus.alu_op, bus.alu_sw} <= fetch_dat;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.result <= bus.acc_in;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    bus.pc     <= 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
